branch_feedback_tracker: RTL and testbench
==========================================

// Module: branch_feedback_tracker
// PURPOSE
//  Initiator/feedback-side partner of the branch predictor. Issues the predictor's
//  request interface when decode sees a conditional branch, queues
//  {pc, prediction} in order, and on resolution in execute pops the oldest entry
//  and drives the predictor's feedback interface (valid/pc/prediction/outcome).
//  Sits between decode, execute and the predictor; flush empties it on redirect.
// PARAMETERS
//  DEPTH       8   in-flight branch entries; power of two, >=2
//  STAT_WIDTH  32  width of performance counters (BP_STATS_EN only)
// PORTS
//  clk                 in   1          clock
//  rst_n               in   1          reset, asynchronous, active-low
//  i_br_valid          in   1          decode presents a conditional branch
//  i_br_pc             in   ADDR_WIDTH branch PC
//  i_br_target         in   ADDR_WIDTH branch target
//  o_br_ready          out  1          entry available (count < DEPTH)
//  o_br_prediction     out  BranchOutcome  prediction returned to fetch
//  o_req_valid         out  1          predictor request valid
//  o_req_pc            out  ADDR_WIDTH predictor request PC
//  o_req_target        out  ADDR_WIDTH predictor request target
//  i_req_prediction    in   BranchOutcome  predictor answer (same cycle)
//  i_res_valid         in   1          execute resolved oldest branch
//  i_res_outcome       in   BranchOutcome  actual outcome
//  i_flush             in   1          pipeline redirect, drop in-flight entries
//  o_fb_valid          out  1          predictor feedback valid
//  o_fb_pc             out  ADDR_WIDTH feedback PC
//  o_fb_prediction     out  BranchOutcome  prediction made for that PC
//  o_fb_outcome        out  BranchOutcome  actual outcome
//  o_mispredict        out  1          pulse with o_fb_valid when pred != outcome
//  o_count             out  $clog2(DEPTH)+1  occupied entries
//  o_underflow         out  1          sticky: resolve seen while empty
// BEHAVIOUR
//  - Reset (async): count=0, pointers=0, o_fb_valid=0, o_fb_pc=0,
//    o_fb_prediction=o_fb_outcome=NOT_TAKEN, o_mispredict=0, o_underflow=0.
//  - push = i_br_valid & o_br_ready & ~i_flush. o_req_valid=push (comb);
//    o_req_pc/o_req_target = i_br_pc/i_br_target; o_br_prediction=i_req_prediction.
//    On push, entry[wr_ptr] <= {i_br_pc, i_req_prediction}; wr_ptr++ mod DEPTH.
//  - o_br_ready = (count != DEPTH). No push into a full queue even if a pop
//    happens the same cycle (ready is not pop-aware).
//  - pop = i_res_valid & (count != 0). Next cycle: o_fb_valid=1, o_fb_pc and
//    o_fb_prediction from entry[rd_ptr], o_fb_outcome=i_res_outcome,
//    o_mispredict = (prediction != outcome). rd_ptr++ mod DEPTH. Latency 1 cycle;
//    o_fb_* hold last value when o_fb_valid=0; o_fb_valid is a 1-cycle pulse.
//  - i_res_valid with count==0: no feedback, o_underflow<=1 (cleared only by reset).
//  - push & pop same cycle: count unchanged, both pointers advance.
//  - i_flush: resolve in same cycle is still popped and fed back; all remaining
//    entries discarded (count<=0, wr_ptr<=rd_ptr after pop); push suppressed.
//  - Pointers wrap at DEPTH; count is the sole full/empty source.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs o_stat_branches, o_stat_mispredicts
//    (STAT_WIDTH each), reset 0, +1 on each feedback / mispredicting feedback,
//    saturate at all-ones. Undefined: ports and counters absent; all else identical.
// TESTING
//  1 reset, pc=0x100 push w/ pred TAKEN, resolve TAKEN -> next cycle fb_valid=1,
//    fb_pc=0x100, fb_pred=TAKEN, mispredict=0, count back to 0.
//  2 push 8 branches (0x200..0x21C) -> o_br_ready=0, 9th push ignored, o_req_valid=0;
//    8 resolves -> fb PCs 0x200..0x21C in order, pointers wrap.
//  3 push 0x300 pred NOT_TAKEN, resolve TAKEN -> mispredict=1 with fb_valid.
//  4 3 in flight, resolve+flush same cycle -> fb for oldest only, count=0, next
//    push lands and feeds back correctly.
//  5 resolve with count=0 -> no fb_valid, o_underflow=1 stays until rst_n low.
//  6 rst_n low mid-stream (async, between edges) -> outputs at reset values at once.

Source files
------------

// File: rtl/branch_feedback_tracker.sv
// branch_feedback_tracker
//   Sits between decode, execute and the branch predictor. Decode's
//   conditional branches are forwarded as predictor requests. Each accepted
//   branch is queued in order as {pc, prediction}. When execute resolves the
//   oldest branch, that entry is popped, and one cycle later it is presented
//   on the predictor feedback interface together with the actual outcome.
//   A flush discards every in-flight entry. A resolve arriving in the same
//   cycle as a flush is still fed back.
//
//   Optional feature: define BP_STATS_EN to add the saturating counters
//   o_stat_branches and o_stat_mispredicts.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_br_valid/pc/target       branch presented by decode
//   o_br_ready                 queue has a free entry
//   o_br_prediction            predictor answer passed back to fetch
//   o_req_valid/pc/target      predictor request (combinational from decode)
//   i_req_prediction           predictor answer, same cycle as request
//   i_res_valid, i_res_outcome execute resolved the oldest branch
//   i_flush                    pipeline redirect
//   o_fb_valid/pc/prediction/outcome, o_mispredict
//                              predictor feedback, 1 cycle after resolve
//   o_count                    occupied entries
//   o_underflow                sticky: resolve seen while empty
//   o_stat_branches, o_stat_mispredicts (BP_STATS_EN only)
module branch_feedback_tracker #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_br_valid,
  input  logic [ADDR_WIDTH-1:0]    i_br_pc,
  input  logic [ADDR_WIDTH-1:0]    i_br_target,
  output logic                     o_br_ready,
  output logic                     o_br_prediction,
  output logic                     o_req_valid,
  output logic [ADDR_WIDTH-1:0]    o_req_pc,
  output logic [ADDR_WIDTH-1:0]    o_req_target,
  input  logic                     i_req_prediction,
  input  logic                     i_res_valid,
  input  logic                     i_res_outcome,
  input  logic                     i_flush,
  output logic                     o_fb_valid,
  output logic [ADDR_WIDTH-1:0]    o_fb_pc,
  output logic                     o_fb_prediction,
  output logic                     o_fb_outcome,
  output logic                     o_mispredict,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_underflow
`ifdef BP_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    o_stat_branches,
  output logic [STAT_WIDTH-1:0]    o_stat_mispredicts
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } bp_outcome_e;

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic                  pred_mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;

  logic                  fb_valid_q;
  logic [ADDR_WIDTH-1:0] fb_pc_q;
  logic                  fb_pred_q;
  logic                  fb_outcome_q;
  logic                  mispredict_q;
  logic                  underflow_q;

  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  pop_mis;

  assign empty      = (count_q == '0);
  // Ready only looks at occupancy. A full queue refuses a push even when a
  // pop happens in the same cycle.
  assign o_br_ready = (count_q != CW'(DEPTH));
  assign push       = i_br_valid & o_br_ready & ~i_flush;
  assign pop        = i_res_valid & ~empty;
  assign pop_mis    = pred_mem_q[rd_ptr_q] != i_res_outcome;

  assign o_req_valid     = push;
  assign o_req_pc        = i_br_pc;
  assign o_req_target    = i_br_target;
  assign o_br_prediction = i_req_prediction;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (i_flush) begin
      // Realign the write pointer just past the entry being popped, if any.
      // This discards everything still queued.
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end
  end

  // Queue storage needs no reset. Count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= i_br_pc;
      pred_mem_q[wr_ptr_q] <= i_req_prediction;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fb_valid_q   <= 1'b0;
      fb_pc_q      <= '0;
      fb_pred_q    <= NOT_TAKEN;
      fb_outcome_q <= NOT_TAKEN;
      mispredict_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fb_valid_q   <= pop;
      mispredict_q <= pop & pop_mis;
      if (pop) begin
        fb_pc_q      <= pc_mem_q[rd_ptr_q];
        fb_pred_q    <= pred_mem_q[rd_ptr_q];
        fb_outcome_q <= i_res_outcome;
      end
      if (i_res_valid && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign o_fb_valid      = fb_valid_q;
  assign o_fb_pc         = fb_pc_q;
  assign o_fb_prediction = fb_pred_q;
  assign o_fb_outcome    = fb_outcome_q;
  assign o_mispredict    = mispredict_q;
  assign o_count         = count_q;
  assign o_underflow     = underflow_q;

`ifdef BP_STATS_EN
  logic [STAT_WIDTH-1:0] stat_br_q;
  logic [STAT_WIDTH-1:0] stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (pop && stat_br_q != '1) begin
        stat_br_q <= stat_br_q + 1'b1;
      end
      if (pop && pop_mis && stat_mis_q != '1) begin
        stat_mis_q <= stat_mis_q + 1'b1;
      end
    end
  end

  assign o_stat_branches    = stat_br_q;
  assign o_stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_feedback_tracker.sv
module tb_branch_feedback_tracker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_br_valid;
  logic [AW-1:0] i_br_pc;
  logic [AW-1:0] i_br_target;
  logic          o_br_ready;
  logic          o_br_prediction;
  logic          o_req_valid;
  logic [AW-1:0] o_req_pc;
  logic [AW-1:0] o_req_target;
  logic          i_req_prediction;
  logic          i_res_valid;
  logic          i_res_outcome;
  logic          i_flush;
  logic          o_fb_valid;
  logic [AW-1:0] o_fb_pc;
  logic          o_fb_prediction;
  logic          o_fb_outcome;
  logic          o_mispredict;
  logic [3:0]    o_count;
  logic          o_underflow;
`ifdef BP_STATS_EN
  logic [31:0]   o_stat_branches;
  logic [31:0]   o_stat_mispredicts;
`endif

  branch_feedback_tracker #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .STAT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_br_valid(i_br_valid), .i_br_pc(i_br_pc), .i_br_target(i_br_target),
    .o_br_ready(o_br_ready), .o_br_prediction(o_br_prediction),
    .o_req_valid(o_req_valid), .o_req_pc(o_req_pc), .o_req_target(o_req_target),
    .i_req_prediction(i_req_prediction),
    .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome), .i_flush(i_flush),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
    .o_fb_outcome(o_fb_outcome), .o_mispredict(o_mispredict),
    .o_count(o_count), .o_underflow(o_underflow)
`ifdef BP_STATS_EN
    , .o_stat_branches(o_stat_branches), .o_stat_mispredicts(o_stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic          pred;
  } entry_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic          pred;
    logic          outcome;
    logic          mis;
  } fb_t;

  typedef struct {
    logic          bv;
    logic [AW-1:0] pc;
    logic          pred;
    logic          rv;
    logic          oc;
    logic          fl;
    int unsigned   exp_count;
  } vec_t;

  entry_t m_q[$];
  fb_t    exp_q[$];
  logic   m_uf;
  int     n_pass  = 0;
  int     n_total = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    i_br_valid = 1'b0; i_br_pc = '0; i_br_target = '0; i_req_prediction = 1'b0;
    i_res_valid = 1'b0; i_res_outcome = 1'b0; i_flush = 1'b0;
  endtask

  // Called just after a falling edge. Drives one cycle of stimulus, checks the
  // combinational request side, updates the reference queue, then checks the
  // registered outputs after the rising edge. Returns at the next falling edge.
  task automatic step(input logic bv, input logic [AW-1:0] pc, input logic pred,
                      input logic rv, input logic oc, input logic fl);
    logic   exp_push;
    entry_t e;
    fb_t    f;
    i_br_valid = bv; i_br_pc = pc; i_br_target = pc + 32'h40; i_req_prediction = pred;
    i_res_valid = rv; i_res_outcome = oc; i_flush = fl;
    #1;
    exp_push = bv && (m_q.size() != DEPTH) && !fl;
    chk("br_ready", {31'd0, o_br_ready}, {31'd0, m_q.size() != DEPTH});
    chk("req_valid", {31'd0, o_req_valid}, {31'd0, exp_push});
    if (exp_push) begin
      chk("req_pc", o_req_pc, pc);
      chk("req_target", o_req_target, pc + 32'h40);
      chk("br_prediction", {31'd0, o_br_prediction}, {31'd0, pred});
    end
    if (rv && m_q.size() != 0) begin
      e = m_q.pop_front();
      f.pc = e.pc; f.pred = e.pred; f.outcome = oc; f.mis = (e.pred != oc);
      exp_q.push_back(f);
    end else if (rv) begin
      m_uf = 1'b1;
    end
    if (fl) m_q.delete();
    if (exp_push) begin
      e.pc = pc; e.pred = pred;
      m_q.push_back(e);
    end
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      f = exp_q.pop_front();
      chk("fb_valid", {31'd0, o_fb_valid}, 32'd1);
      chk("fb_pc", o_fb_pc, f.pc);
      chk("fb_prediction", {31'd0, o_fb_prediction}, {31'd0, f.pred});
      chk("fb_outcome", {31'd0, o_fb_outcome}, {31'd0, f.outcome});
      chk("mispredict", {31'd0, o_mispredict}, {31'd0, f.mis});
    end else begin
      chk("fb_valid_idle", {31'd0, o_fb_valid}, 32'd0);
      chk("mispredict_idle", {31'd0, o_mispredict}, 32'd0);
    end
    chk("count", {28'd0, o_count}, m_q.size());
    chk("underflow", {31'd0, o_underflow}, {31'd0, m_uf});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fb_valid"}, {31'd0, o_fb_valid}, 32'd0);
    chk({tag, "_fb_pc"}, o_fb_pc, 32'd0);
    chk({tag, "_fb_pred"}, {31'd0, o_fb_prediction}, 32'd0);
    chk({tag, "_fb_outcome"}, {31'd0, o_fb_outcome}, 32'd0);
    chk({tag, "_mispredict"}, {31'd0, o_mispredict}, 32'd0);
    chk({tag, "_count"}, {28'd0, o_count}, 32'd0);
    chk({tag, "_underflow"}, {31'd0, o_underflow}, 32'd0);
    chk({tag, "_br_ready"}, {31'd0, o_br_ready}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    // Directed sequence from reset. exp_count was worked out by hand.
    vecs[0] = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // push 0x100 TAKEN
    vecs[1] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 0}; // resolve TAKEN, correct
    vecs[2] = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // push 0x300 NOT_TAKEN
    vecs[3] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 0}; // resolve TAKEN, mispredict
    vecs[4] = '{1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[5] = '{1'b1, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // push+pop same cycle
    vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[7] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 0}; // idle

    idle_inputs();
    m_uf  = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].bv, vecs[i].pc, vecs[i].pred, vecs[i].rv, vecs[i].oc, vecs[i].fl);
      chk($sformatf("vec%0d_count", i), {28'd0, o_count}, vecs[i].exp_count);
    end

    // Fill the queue. The pointers start at 4 here, so this wraps.
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h200 + 32'(i * 4), 1'(i % 2), 1'b0, 1'b0, 1'b0);
    chk("full_count", {28'd0, o_count}, 32'd8);
    chk("full_ready", {31'd0, o_br_ready}, 32'd0);
    step(1'b1, 32'h220, 1'b1, 1'b0, 1'b0, 1'b0);            // ignored 9th push
    step(1'b1, 32'h224, 1'b1, 1'b1, 1'b1, 1'b0);            // full: pop only, no push
    for (int i = 0; i < 7; i++)
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'(i % 3 == 0), 1'b0);
    chk("drained_count", {28'd0, o_count}, 32'd0);

    // Three in flight, then resolve+flush with a push attempt in the same cycle.
    step(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h608, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h60C, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_count", {28'd0, o_count}, 32'd0);
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0);

    // Resolve while empty: no feedback, sticky underflow.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("underflow_sticky", {31'd0, o_underflow}, 32'd1);

    // Asynchronous reset while feedback is being presented.
    i_res_valid = 1'b1; i_res_outcome = 1'b1;
    @(posedge clk); #2;
    chk("pre_reset_fb_valid", {31'd0, o_fb_valid}, 32'd1);
    chk("pre_reset_mispredict", {31'd0, o_mispredict}, 32'd1);
    chk("pre_reset_fb_pc", o_fb_pc, 32'h700);
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    idle_inputs();
    m_q.delete(); exp_q.delete(); m_uf = 1'b0;
    rst_n = 1'b1;
    step(1'b1, 32'h800, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
